// File: rtl/shot_sequencer_if.sv
// Bundles the frame, key, ball-motion and pocket inputs with the sequencer's registered outputs.
// No latency of its own; carries signals between the sequencer and whatever drives it.
// No backpressure: every signal is level or single-cycle pulse.
interface shot_sequencer_if #(
    parameter int NUM_BALLS = 4
);
    // Inputs to the sequencer
    logic                 startOfFrame;
    logic                 keyUp;
    logic                 keyDown;
    logic                 keyLeft;
    logic                 keyRight;
    logic                 keyEnter;
    logic [NUM_BALLS-1:0] ballMoving;
    logic                 whiteInHole;

    // Outputs from the sequencer
    logic                 chargeUp;
    logic                 chargeDown;
    logic                 chargeLeft;
    logic                 chargeRight;
    logic                 releaseBall;
    logic [1:0]           state;
    logic [7:0]           shotCount;
    logic                 rollTimeout;
    logic                 respawnWhite;

    // Driver side: game inputs out, sequencer status in
    modport master (
        output startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyEnter,
        output ballMoving, whiteInHole,
        input  chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
        input  state, shotCount, rollTimeout, respawnWhite
    );

    // Sequencer side
    modport slave (
        input  startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyEnter,
        input  ballMoving, whiteInHole,
        output chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
        output state, shotCount, rollTimeout, respawnWhite
    );
endinterface

// File: rtl/shot_sequencer.sv
// Shot sequencer: aim/charge, release, roll monitoring and settle for a pool game.
// All outputs registered: one cycle from the sampled input (startOfFrame, key edge) to the output.
// No backpressure; inputs are sampled every cycle and pulses last exactly one cycle.
module shot_sequencer #(
    parameter int NUM_BALLS       = 4,
    parameter int STILL_FRAMES    = 8,
    parameter int MAX_ROLL_FRAMES = 1800,
    parameter int MAX_CHARGE      = 8
) (
    input  logic               clk,
    input  logic               resetN,
    shot_sequencer_if.slave    bus
);

    // Signed charge width holds +/-MAX_CHARGE; counters hold their limits without wrapping
    localparam int CW = $clog2(MAX_CHARGE + 1) + 1;
    localparam int SW = $clog2(STILL_FRAMES + 1);
    localparam int RW = $clog2(MAX_ROLL_FRAMES + 1);

    localparam logic signed [CW-1:0] C_MAX  = CW'(MAX_CHARGE);
    localparam logic signed [CW-1:0] C_MIN  = -C_MAX;
    localparam logic signed [CW-1:0] C_ONE  = CW'(1);
    localparam logic signed [CW-1:0] C_ZERO = '0;
    localparam logic [SW-1:0]        STILL_LIM = SW'(STILL_FRAMES);
    localparam logic [RW-1:0]        ROLL_LIM  = RW'(MAX_ROLL_FRAMES);

    typedef enum logic [1:0] {
        S_AIM     = 2'd0,
        S_RELEASE = 2'd1,
        S_ROLLING = 2'd2,
        S_SETTLE  = 2'd3
    } state_t;

    state_t                 r_state, w_state;
    logic signed [CW-1:0]   r_x, w_x;
    logic signed [CW-1:0]   r_y, w_y;
    logic [SW-1:0]          r_still, w_still;
    logic [RW-1:0]          r_roll, w_roll;
    logic                   r_hole, w_hole;
    logic                   r_enter_prev;
    logic                   r_cu, w_cu;
    logic                   r_cd, w_cd;
    logic                   r_cl, w_cl;
    logic                   r_cr, w_cr;
    logic                   r_rel, w_rel;
    logic [7:0]             r_shot, w_shot;
    logic                   r_timeout, w_timeout;
    logic                   r_respawn, w_respawn;
    logic                   w_enter_edge;
    logic                   w_any_moving;

    assign w_enter_edge = bus.keyEnter & ~r_enter_prev;
    assign w_any_moving = |bus.ballMoving;

    // State register
    always_ff @(posedge clk) begin
        if (!resetN) r_state <= S_AIM;
        else         r_state <= w_state;
    end

    // Next-state and next-output logic; every output is decided here and registered below
    always_comb begin
        w_state   = r_state;
        w_x       = r_x;
        w_y       = r_y;
        w_still   = r_still;
        w_roll    = r_roll;
        w_hole    = r_hole;
        w_cu      = 1'b0;
        w_cd      = 1'b0;
        w_cl      = 1'b0;
        w_cr      = 1'b0;
        w_rel     = 1'b0;
        w_shot    = r_shot;
        w_timeout = r_timeout;
        w_respawn = 1'b0;

        case (r_state)
            S_AIM: begin
                if (bus.startOfFrame) begin
                    // Opposing keys held together cancel out on each axis
                    if (bus.keyUp && !bus.keyDown && (r_y < C_MAX)) begin
                        w_cu = 1'b1;
                        w_y  = r_y + C_ONE;
                    end else if (bus.keyDown && !bus.keyUp && (r_y > C_MIN)) begin
                        w_cd = 1'b1;
                        w_y  = r_y - C_ONE;
                    end
                    if (bus.keyLeft && !bus.keyRight && (r_x < C_MAX)) begin
                        w_cl = 1'b1;
                        w_x  = r_x + C_ONE;
                    end else if (bus.keyRight && !bus.keyLeft && (r_x > C_MIN)) begin
                        w_cr = 1'b1;
                        w_x  = r_x - C_ONE;
                    end
                end
                // A shot with no charge would do nothing, so it is not taken.
                // Release bookkeeping happens on entry so it is visible during the RELEASE cycle.
                if (w_enter_edge && ((r_x != C_ZERO) || (r_y != C_ZERO))) begin
                    w_state   = S_RELEASE;
                    w_rel     = 1'b1;
                    w_shot    = (r_shot == 8'hFF) ? r_shot : r_shot + 8'd1;
                    w_x       = C_ZERO;
                    w_y       = C_ZERO;
                    w_still   = '0;
                    w_roll    = '0;
                    w_timeout = 1'b0;
                    w_hole    = 1'b0;
                    w_cu      = 1'b0;
                    w_cd      = 1'b0;
                    w_cl      = 1'b0;
                    w_cr      = 1'b0;
                end
            end

            S_RELEASE: begin
                w_state = S_ROLLING;
            end

            S_ROLLING: begin
                if (bus.whiteInHole) w_hole = 1'b1;
                if (bus.startOfFrame) begin
                    w_roll  = r_roll + RW'(1);
                    w_still = w_any_moving ? '0 : r_still + SW'(1);
                    // Stillness is checked first so a tie with the timeout is not a timeout
                    if (w_still == STILL_LIM) begin
                        w_state   = S_SETTLE;
                        w_timeout = 1'b0;
                        w_respawn = w_hole;
                    end else if (w_roll == ROLL_LIM) begin
                        w_state   = S_SETTLE;
                        w_timeout = 1'b1;
                        w_respawn = w_hole;
                    end
                end
            end

            S_SETTLE: begin
                if (bus.startOfFrame) w_state = S_AIM;
            end

            default: begin
                w_state = S_AIM;
            end
        endcase
    end

    // Datapath, counters, flags and registered outputs
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_x          <= '0;
            r_y          <= '0;
            r_still      <= '0;
            r_roll       <= '0;
            r_hole       <= 1'b0;
            r_enter_prev <= 1'b0;
            r_cu         <= 1'b0;
            r_cd         <= 1'b0;
            r_cl         <= 1'b0;
            r_cr         <= 1'b0;
            r_rel        <= 1'b0;
            r_shot       <= 8'd0;
            r_timeout    <= 1'b0;
            r_respawn    <= 1'b0;
        end else begin
            r_x          <= w_x;
            r_y          <= w_y;
            r_still      <= w_still;
            r_roll       <= w_roll;
            r_hole       <= w_hole;
            r_enter_prev <= bus.keyEnter;
            r_cu         <= w_cu;
            r_cd         <= w_cd;
            r_cl         <= w_cl;
            r_cr         <= w_cr;
            r_rel        <= w_rel;
            r_shot       <= w_shot;
            r_timeout    <= w_timeout;
            r_respawn    <= w_respawn;
        end
    end

    assign bus.chargeUp     = r_cu;
    assign bus.chargeDown   = r_cd;
    assign bus.chargeLeft   = r_cl;
    assign bus.chargeRight  = r_cr;
    assign bus.releaseBall  = r_rel;
    assign bus.state        = r_state;
    assign bus.shotCount    = r_shot;
    assign bus.rollTimeout  = r_timeout;
    assign bus.respawnWhite = r_respawn;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed bench for shot_sequencer: vector table for aiming/release, hand sequences for rolls and reset.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
// No backpressure involved.
module tb_shot_sequencer;

    logic clk;
    logic resetN;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulses;

    shot_sequencer_if #(.NUM_BALLS(4)) bus ();

    shot_sequencer #(
        .NUM_BALLS       (4),
        .STILL_FRAMES    (8),
        .MAX_ROLL_FRAMES (1800),
        .MAX_CHARGE      (8)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // in    = {sof, up, down, left, right, enter}
    // pul   = {chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall}
    typedef struct {
        logic [5:0] in;
        logic [1:0] st;
        logic [4:0] pul;
        logic [7:0] shot;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sof_cycle();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
    endtask

    function automatic int pulses();
        return int'({bus.chargeUp, bus.chargeDown, bus.chargeLeft, bus.chargeRight, bus.releaseBall});
    endfunction

    initial begin
        resetN           = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.keyUp        = 1'b0;
        bus.keyDown      = 1'b0;
        bus.keyLeft      = 1'b0;
        bus.keyRight     = 1'b0;
        bus.keyEnter     = 1'b0;
        bus.ballMoving   = 4'b0000;
        bus.whiteInHole  = 1'b0;

        //                in          st    pul       shot
        vecs[0]  = '{6'b010000, 2'd0, 5'b00000, 8'd0}; // keyUp without frame: nothing
        vecs[1]  = '{6'b111000, 2'd0, 5'b00000, 8'd0}; // up+down cancel
        vecs[2]  = '{6'b100110, 2'd0, 5'b00000, 8'd0}; // left+right cancel
        vecs[3]  = '{6'b110100, 2'd0, 5'b10100, 8'd0}; // up+left together: y=1 x=1
        vecs[4]  = '{6'b010100, 2'd0, 5'b00000, 8'd0}; // no frame: pulses were one cycle
        vecs[5]  = '{6'b101000, 2'd0, 5'b01000, 8'd0}; // down: y=0
        vecs[6]  = '{6'b100010, 2'd0, 5'b00010, 8'd0}; // right: x=0
        vecs[7]  = '{6'b000001, 2'd0, 5'b00000, 8'd0}; // Enter edge with zero charge ignored
        vecs[8]  = '{6'b000000, 2'd0, 5'b00000, 8'd0};
        vecs[9]  = '{6'b101000, 2'd0, 5'b01000, 8'd0}; // down: y=-1
        vecs[10] = '{6'b000001, 2'd1, 5'b00001, 8'd1}; // Enter edge: RELEASE
        vecs[11] = '{6'b000001, 2'd2, 5'b00000, 8'd1}; // ROLLING, held Enter no new shot
        vecs[12] = '{6'b110000, 2'd2, 5'b00000, 8'd1}; // keys ignored while rolling
        vecs[13] = '{6'b000000, 2'd2, 5'b00000, 8'd1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_state", int'(bus.state), 0);
        chk("reset_pulses", pulses(), 0);
        chk("reset_shot", int'(bus.shotCount), 0);
        chk("reset_timeout", int'(bus.rollTimeout), 0);
        chk("reset_respawn", int'(bus.respawnWhite), 0);
        resetN = 1'b1;

        // Table: aiming, key cancellation, Enter edge handling, release
        bus.ballMoving = 4'b0001;
        for (int i = 0; i < 14; i++) begin
            {bus.startOfFrame, bus.keyUp, bus.keyDown, bus.keyLeft, bus.keyRight, bus.keyEnter} = vecs[i].in;
            tick();
            chk($sformatf("vec%0d_state", i), int'(bus.state), int'(vecs[i].st));
            chk($sformatf("vec%0d_pulses", i), pulses(), int'(vecs[i].pul));
            chk($sformatf("vec%0d_shot", i), int'(bus.shotCount), int'(vecs[i].shot));
        end
        {bus.startOfFrame, bus.keyUp, bus.keyDown, bus.keyLeft, bus.keyRight, bus.keyEnter} = 6'b0;

        // Roll ends by stillness: 5 moving frames then 8 still frames
        bus.ballMoving = 4'b0010;
        for (int f = 0; f < 5; f++) begin
            sof_cycle();
            tick();
        end
        chk("still_moving_state", int'(bus.state), 2);
        bus.ballMoving = 4'b0000;
        for (int f = 1; f <= 8; f++) begin
            sof_cycle();
            chk($sformatf("still_frame%0d_state", f), int'(bus.state), (f == 8) ? 3 : 2);
            if (f == 8) begin
                chk("still_timeout", int'(bus.rollTimeout), 0);
                chk("still_respawn", int'(bus.respawnWhite), 0);
            end
            tick();
        end
        chk("settle_waits_frame", int'(bus.state), 3);
        sof_cycle();
        chk("settle_to_aim", int'(bus.state), 0);
        tick();

        // keyUp held 12 frames: 8 pulses, each one cycle after its frame pulse
        n_pulses = 0;
        bus.keyUp = 1'b1;
        for (int f = 0; f < 12; f++) begin
            sof_cycle();
            n_pulses += int'(bus.chargeUp);
            chk($sformatf("up_frame%0d_pulse", f), int'(bus.chargeUp), (f < 8) ? 1 : 0);
            tick();
            n_pulses += int'(bus.chargeUp);
            chk($sformatf("up_frame%0d_gap", f), int'(bus.chargeUp), 0);
        end
        bus.keyUp = 1'b0;
        chk("up_pulse_total", n_pulses, 8);

        // Shoot and keep Enter held through the whole roll
        bus.keyEnter = 1'b1;
        tick();
        chk("shot2_state", int'(bus.state), 1);
        chk("shot2_release", int'(bus.releaseBall), 1);
        chk("shot2_count", int'(bus.shotCount), 2);
        tick();
        chk("shot2_rolling", int'(bus.state), 2);
        chk("shot2_release_one", int'(bus.releaseBall), 0);

        // Balls never stop: timeout after 1800 frames, pocketed white mid-roll
        bus.ballMoving = 4'b1111;
        for (int f = 1; f <= 1800; f++) begin
            if (f == 900) begin
                bus.whiteInHole = 1'b1;
                tick();
                bus.whiteInHole = 1'b0;
            end
            sof_cycle();
            if (f == 1799) chk("timeout_f1799_state", int'(bus.state), 2);
            if (f == 1800) begin
                chk("timeout_state", int'(bus.state), 3);
                chk("timeout_flag", int'(bus.rollTimeout), 1);
                chk("timeout_respawn", int'(bus.respawnWhite), 1);
            end
            tick();
            if (f == 1800) begin
                chk("respawn_one_cycle", int'(bus.respawnWhite), 0);
                chk("timeout_hold_settle", int'(bus.state), 3);
            end
        end
        bus.ballMoving = 4'b0000;
        sof_cycle();
        chk("timeout_to_aim", int'(bus.state), 0);

        // Enter still held from before: charging must not trigger a shot without a fresh edge
        bus.keyUp = 1'b1;
        sof_cycle();
        bus.keyUp = 1'b0;
        chk("held_enter_charge", int'(bus.chargeUp), 1);
        tick();
        tick();
        chk("held_enter_no_shot_state", int'(bus.state), 0);
        chk("held_enter_no_shot_count", int'(bus.shotCount), 2);
        chk("timeout_kept_in_aim", int'(bus.rollTimeout), 1);

        // Fresh Enter edge: third shot clears the timeout flag
        bus.keyEnter = 1'b0;
        tick();
        bus.keyEnter = 1'b1;
        tick();
        chk("shot3_state", int'(bus.state), 1);
        chk("shot3_count", int'(bus.shotCount), 3);
        chk("shot3_timeout_clr", int'(bus.rollTimeout), 0);
        tick();
        chk("shot3_rolling", int'(bus.state), 2);

        // Reset in the middle of a roll
        bus.ballMoving = 4'b0100;
        sof_cycle();
        resetN = 1'b0;
        tick();
        chk("midroll_reset_state", int'(bus.state), 0);
        chk("midroll_reset_shot", int'(bus.shotCount), 0);
        chk("midroll_reset_pulses", pulses(), 0);
        chk("midroll_reset_timeout", int'(bus.rollTimeout), 0);
        chk("midroll_reset_respawn", int'(bus.respawnWhite), 0);
        resetN = 1'b1;
        bus.keyEnter = 1'b0;
        tick();
        // Charges are zero after reset, so an Enter edge alone is ignored
        bus.keyEnter = 1'b1;
        tick();
        chk("post_reset_enter_ignored", int'(bus.state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
